coco_id_ex: RTL and testbench
=============================

COCO_ID_EX -- requirements
Module: coco_id_ex

Interface
REQ-001 SHALL have a single clock domain; reset is asynchronous and active-low.
REQ-002 Clk  in  1  rising-edge clock.
REQ-003 Rst_n  in  1  async active-low reset.
REQ-004 ID_A, ID_B  in  32 each  decode-stage rs/rt register-file values.
REQ-005 ID_Imm  in  32  sign/zero-extended immediate; ID_BSel in 1, 1 = B operand from immediate.
REQ-006 ID_Rs, ID_Rt, ID_Rd  in  5 each  source/destination register numbers.
REQ-007 ID_Ctrl  in  5  ALU operation code, passed unchanged; ID_RegWrite, ID_MemRead, ID_Valid  in  1 each.
REQ-008 Stall  in  1  hold stage contents; Flush  in  1  replace stage contents with bubble.
REQ-009 MEM_RegWrite in 1, MEM_Rd in 5, MEM_Result in 32: EX/MEM forwarding source.
REQ-010 WB_RegWrite in 1, WB_Rd in 5, WB_Result in 32: MEM/WB forwarding source.
REQ-011 EX_A, EX_B  out  32 each  forwarded ALU operands; EX_Ctrl  out  5.
REQ-012 EX_Rd out 5; EX_RegWrite, EX_MemRead, EX_Valid  out  1 each.
REQ-013 HazardStall  out  1  load-use hazard request to the upstream stall logic.

Function
REQ-014 Stage registers SHALL be: OpA, OpB, Imm, BSel, Rs, Rt, Rd, Ctrl, RegWrite, MemRead, Valid.
REQ-015 Rising edge, Flush=1: Valid, RegWrite, MemRead SHALL clear; Ctrl, Rs, Rt, Rd SHALL clear to 0; other registers don't-care; Flush SHALL take priority over Stall.
REQ-016 Rising edge, Flush=0, Stall=0: all registers SHALL load the corresponding ID_* inputs (one-cycle latency ID->EX).
REQ-017 Rising edge, Flush=0, Stall=1: Ctrl, Rs, Rt, Rd, BSel, Imm, RegWrite, MemRead, Valid SHALL hold; OpA SHALL load the current forwarded A value and OpB the current forwarded rt value, so WB-forwarded data is not lost across a multi-cycle stall.
REQ-018 Forwarded A (combinational): MEM_Result if MEM_RegWrite=1, MEM_Rd=Rs, Rs!=0; else WB_Result if WB_RegWrite=1, WB_Rd=Rs, Rs!=0; else OpA.
REQ-019 Forwarded rt value: same rule as REQ-018 using Rt and OpB; MEM source SHALL have priority over WB.
REQ-020 EX_A SHALL equal forwarded A; EX_B SHALL equal Imm when BSel=1, else forwarded rt value.
REQ-021 Register 0 SHALL never be a forwarding match, even when a source asserts RegWrite with Rd=0.
REQ-022 EX_Ctrl, EX_Rd, EX_RegWrite, EX_MemRead, EX_Valid SHALL drive the stage registers directly.
REQ-023 HazardStall SHALL be 1 iff Valid=1, MemRead=1, Rd!=0, ID_Valid=1, and either Rd=ID_Rs or (Rd=ID_Rt and ID_BSel=0); otherwise 0.
REQ-024 HazardStall SHALL be purely combinational with no dependence on Stall/Flush; the stage does not act on it itself.
REQ-025 Forwarding SHALL be bit-exact 32-bit; no arithmetic is performed in this block.

Reset
REQ-026 Rst_n=0 SHALL immediately, without a clock edge, clear all stage registers to 0.
REQ-027 While Rst_n=0, EX_Valid, EX_RegWrite, EX_MemRead, HazardStall SHALL be 0, EX_Ctrl=0, EX_Rd=0, and EX_A/EX_B SHALL reflect zeroed registers (0 unless forwarded from a source with Rd matching register 0, which is excluded).
REQ-028 Reset asserted mid-stall or mid-flush SHALL override both; first edge after release SHALL follow REQ-015..017 normally.

Verification
REQ-029 Pass-through: ID_A=0x11, ID_B=0x22, Rs=1, Rt=2, BSel=0, no forwarding, one edge -> EX_A=0x11, EX_B=0x22, EX_Valid=1, EX_Ctrl=ID_Ctrl.
REQ-030 Priority: Rs=Rt=5, MEM_Rd=5 MEM_Result=0xAAAA, WB_Rd=5 WB_Result=0xBBBB, both RegWrite=1 -> EX_A=EX_B=0xAAAA; MEM_RegWrite=0 -> both 0xBBBB; Rs=Rt=0 -> both the ID values.
REQ-031 Immediate select: BSel=1, Imm=0xFFFF8000, MEM_Rd=Rt with RegWrite=1 -> EX_B=0xFFFF8000, EX_A unaffected.
REQ-032 Stall retention: Rs=3 captured, WB_Rd=3 WB_Result=0x1234 for one cycle with Stall=1, then WB_RegWrite=0, Stall held 2 more cycles -> EX_A stays 0x1234.
REQ-033 Load-use: EX holds MemRead=1, Rd=7, Valid=1; ID_Rs=7, ID_Valid=1 -> HazardStall=1; ID_BSel=1 with only ID_Rt=7 -> 0; Rd=0 -> 0.
REQ-034 Flush/reset: Stall=1 and Flush=1 same edge -> EX_Valid=0, EX_RegWrite=0; Rst_n pulsed low between edges -> outputs clear immediately without a clock edge.

Source files
------------

// File: rtl/coco_id_ex.sv
// coco_id_ex: ID/EX pipeline stage with operand forwarding and load-use detection.
//
// Captures decode-stage operands and control each cycle, forwards results from
// the EX/MEM and MEM/WB stages onto the ALU operands, and flags load-use hazards
// for the upstream stall logic.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_id_*                decode-stage operands, immediate, register numbers, control
//   i_stall, i_flush      hold stage / replace stage with a bubble (flush wins)
//   i_mem_*, i_wb_*       forwarding sources (regwrite, destination, result)
//   o_ex_a, o_ex_b        forwarded ALU operands (B may be the immediate)
//   o_ex_ctrl, o_ex_rd    ALU op code and destination register
//   o_ex_regwrite, o_ex_memread, o_ex_valid  stage control flags
//   o_hazard_stall        load-use hazard request
module coco_id_ex (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_id_a,
  input  logic [31:0] i_id_b,
  input  logic [31:0] i_id_imm,
  input  logic        i_id_bsel,
  input  logic [4:0]  i_id_rs,
  input  logic [4:0]  i_id_rt,
  input  logic [4:0]  i_id_rd,
  input  logic [4:0]  i_id_ctrl,
  input  logic        i_id_regwrite,
  input  logic        i_id_memread,
  input  logic        i_id_valid,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_mem_regwrite,
  input  logic [4:0]  i_mem_rd,
  input  logic [31:0] i_mem_result,
  input  logic        i_wb_regwrite,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_result,
  output logic [31:0] o_ex_a,
  output logic [31:0] o_ex_b,
  output logic [4:0]  o_ex_ctrl,
  output logic [4:0]  o_ex_rd,
  output logic        o_ex_regwrite,
  output logic        o_ex_memread,
  output logic        o_ex_valid,
  output logic        o_hazard_stall
);

  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [31:0] r_imm;
  logic        r_bsel;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_rd;
  logic [4:0]  r_ctrl;
  logic        r_regwrite;
  logic        r_memread;
  logic        r_valid;

  logic        w_mem_hit_a;
  logic        w_wb_hit_a;
  logic        w_mem_hit_b;
  logic        w_wb_hit_b;
  logic [31:0] w_fwd_a;
  logic [31:0] w_fwd_b;

  // Register 0 is hard-wired zero, so it never matches a forwarding source.
  always_comb begin
    w_mem_hit_a = i_mem_regwrite && (i_mem_rd == r_rs) && (r_rs != 5'd0);
    w_wb_hit_a  = i_wb_regwrite  && (i_wb_rd  == r_rs) && (r_rs != 5'd0);
    w_mem_hit_b = i_mem_regwrite && (i_mem_rd == r_rt) && (r_rt != 5'd0);
    w_wb_hit_b  = i_wb_regwrite  && (i_wb_rd  == r_rt) && (r_rt != 5'd0);
  end

  // The younger (MEM) result takes priority over WB.
  always_comb begin
    w_fwd_a = r_op_a;
    if (w_mem_hit_a) begin
      w_fwd_a = i_mem_result;
    end else if (w_wb_hit_a) begin
      w_fwd_a = i_wb_result;
    end

    w_fwd_b = r_op_b;
    if (w_mem_hit_b) begin
      w_fwd_b = i_mem_result;
    end else if (w_wb_hit_b) begin
      w_fwd_b = i_wb_result;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op_a     <= 32'd0;
      r_op_b     <= 32'd0;
      r_imm      <= 32'd0;
      r_bsel     <= 1'b0;
      r_rs       <= 5'd0;
      r_rt       <= 5'd0;
      r_rd       <= 5'd0;
      r_ctrl     <= 5'd0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      // Bubble: operands, immediate and B-select are left as they are.
      r_rs       <= 5'd0;
      r_rt       <= 5'd0;
      r_rd       <= 5'd0;
      r_ctrl     <= 5'd0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_valid    <= 1'b0;
    end else if (i_stall) begin
      // Capture forwarded values so a WB result seen only once survives the stall.
      r_op_a <= w_fwd_a;
      r_op_b <= w_fwd_b;
    end else begin
      r_op_a     <= i_id_a;
      r_op_b     <= i_id_b;
      r_imm      <= i_id_imm;
      r_bsel     <= i_id_bsel;
      r_rs       <= i_id_rs;
      r_rt       <= i_id_rt;
      r_rd       <= i_id_rd;
      r_ctrl     <= i_id_ctrl;
      r_regwrite <= i_id_regwrite;
      r_memread  <= i_id_memread;
      r_valid    <= i_id_valid;
    end
  end

  always_comb begin
    o_ex_a        = w_fwd_a;
    o_ex_b        = r_bsel ? r_imm : w_fwd_b;
    o_ex_ctrl     = r_ctrl;
    o_ex_rd       = r_rd;
    o_ex_regwrite = r_regwrite;
    o_ex_memread  = r_memread;
    o_ex_valid    = r_valid;
  end

  // rt only counts as a consumer when the B operand really comes from the register file.
  always_comb begin
    o_hazard_stall = r_valid && r_memread && (r_rd != 5'd0) && i_id_valid &&
                     ((r_rd == i_id_rs) || ((r_rd == i_id_rt) && !i_id_bsel));
  end

endmodule

// File: tb/tb_coco_id_ex.sv
module tb_coco_id_ex;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] id_a = '0, id_b = '0, id_imm = '0;
  logic        id_bsel = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0, id_ctrl = '0;
  logic        id_regwrite = 1'b0, id_memread = 1'b0, id_valid = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        mem_rw = 1'b0, wb_rw = 1'b0;
  logic [4:0]  mem_rd = '0, wb_rd = '0;
  logic [31:0] mem_res = '0, wb_res = '0;

  logic [31:0] ex_a, ex_b;
  logic [4:0]  ex_ctrl, ex_rd;
  logic        ex_regwrite, ex_memread, ex_valid, hazard;

  int n_cmp = 0;
  int n_fail = 0;

  coco_id_ex dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_id_a         (id_a),
    .i_id_b         (id_b),
    .i_id_imm       (id_imm),
    .i_id_bsel      (id_bsel),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_id_rd        (id_rd),
    .i_id_ctrl      (id_ctrl),
    .i_id_regwrite  (id_regwrite),
    .i_id_memread   (id_memread),
    .i_id_valid     (id_valid),
    .i_stall        (stall),
    .i_flush        (flush),
    .i_mem_regwrite (mem_rw),
    .i_mem_rd       (mem_rd),
    .i_mem_result   (mem_res),
    .i_wb_regwrite  (wb_rw),
    .i_wb_rd        (wb_rd),
    .i_wb_result    (wb_res),
    .o_ex_a         (ex_a),
    .o_ex_b         (ex_b),
    .o_ex_ctrl      (ex_ctrl),
    .o_ex_rd        (ex_rd),
    .o_ex_regwrite  (ex_regwrite),
    .o_ex_memread   (ex_memread),
    .o_ex_valid     (ex_valid),
    .o_hazard_stall (hazard)
  );

  always #5 clk = ~clk;

  // Reference model: the stage contents as a record; operand values are unknown after a
  // flush until the next normal load or reset.
  typedef struct {
    logic [31:0] a, b, imm;
    logic        bsel;
    logic [4:0]  rs, rt, rd, ctrl;
    logic        rw, mr, v;
    bit          unknown_ops;
  } stage_t;

  stage_t m = '{a: 0, b: 0, imm: 0, bsel: 0, rs: 0, rt: 0, rd: 0, ctrl: 0,
                rw: 0, mr: 0, v: 0, unknown_ops: 0};

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] held);
    if (r == 0) return held;
    if (mem_rw && mem_rd == r) return mem_res;
    if (wb_rw && wb_rd == r) return wb_res;
    return held;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '{a: 0, b: 0, imm: 0, bsel: 0, rs: 0, rt: 0, rd: 0, ctrl: 0,
             rw: 0, mr: 0, v: 0, unknown_ops: 0};
    end else if (flush) begin
      m.rs <= 0; m.rt <= 0; m.rd <= 0; m.ctrl <= 0;
      m.rw <= 0; m.mr <= 0; m.v <= 0;
      m.unknown_ops <= 1;
    end else if (stall) begin
      m.a <= fwd(m.rs, m.a);
      m.b <= fwd(m.rt, m.b);
    end else begin
      m <= '{a: id_a, b: id_b, imm: id_imm, bsel: id_bsel, rs: id_rs, rt: id_rt, rd: id_rd,
             ctrl: id_ctrl, rw: id_regwrite, mr: id_memread, v: id_valid, unknown_ops: 0};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, shortly after each falling edge.
  always @(negedge clk) begin
    #1;
    begin
      bit hz;
      hz = m.v && m.mr && (m.rd != 0) && id_valid &&
           ((m.rd == id_rs) || (m.rd == id_rt && !id_bsel));
      check("m_valid", 32'(ex_valid), 32'(m.v));
      check("m_regwrite", 32'(ex_regwrite), 32'(m.rw));
      check("m_memread", 32'(ex_memread), 32'(m.mr));
      check("m_ctrl", 32'(ex_ctrl), 32'(m.ctrl));
      check("m_rd", 32'(ex_rd), 32'(m.rd));
      check("m_hazard", 32'(hazard), 32'(hz));
      if (!m.unknown_ops) begin
        check("m_ex_a", ex_a, fwd(m.rs, m.a));
        check("m_ex_b", ex_b, m.bsel ? m.imm : fwd(m.rt, m.b));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic randomize_inputs();
    id_a        = $urandom;
    id_b        = $urandom;
    id_imm      = $urandom;
    id_bsel     = ($urandom_range(0, 3) == 0);
    id_rs       = 5'($urandom_range(0, 3));
    id_rt       = 5'($urandom_range(0, 3));
    id_rd       = 5'($urandom_range(0, 3));
    id_ctrl     = 5'($urandom);
    id_regwrite = 1'($urandom);
    id_memread  = 1'($urandom);
    id_valid    = ($urandom_range(0, 4) != 0);
    stall       = ($urandom_range(0, 9) < 3);
    flush       = ($urandom_range(0, 9) == 0);
    mem_rw      = 1'($urandom);
    mem_rd      = 5'($urandom_range(0, 3));
    mem_res     = $urandom;
    wb_rw       = 1'($urandom);
    wb_rd       = 5'($urandom_range(0, 3));
    wb_res      = $urandom;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", 32'(ex_valid), 32'h0);
    check("rst_ex_a", ex_a, 32'h0);
    check("rst_hazard", 32'(hazard), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through
    id_a = 32'h11; id_b = 32'h22; id_rs = 5'd1; id_rt = 5'd2; id_bsel = 1'b0;
    id_ctrl = 5'h0B; id_valid = 1'b1; id_regwrite = 1'b1;
    cyc(); #2;
    check("pt_ex_a", ex_a, 32'h11);
    check("pt_ex_b", ex_b, 32'h22);
    check("pt_valid", 32'(ex_valid), 32'h1);
    check("pt_ctrl", 32'(ex_ctrl), 32'h0B);

    // Forwarding priority
    @(negedge clk);
    id_rs = 5'd5; id_rt = 5'd5; id_a = 32'h100; id_b = 32'h200;
    cyc();
    stall = 1'b1;
    mem_rw = 1'b1; mem_rd = 5'd5; mem_res = 32'hAAAA;
    wb_rw = 1'b1; wb_rd = 5'd5; wb_res = 32'hBBBB;
    #2;
    check("prio_mem_a", ex_a, 32'hAAAA);
    check("prio_mem_b", ex_b, 32'hAAAA);
    mem_rw = 1'b0;
    #1;
    check("prio_wb_a", ex_a, 32'hBBBB);
    check("prio_wb_b", ex_b, 32'hBBBB);
    @(negedge clk);
    stall = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_a = 32'h300; id_b = 32'h400;
    mem_rw = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
    cyc(); #2;
    check("r0_ex_a", ex_a, 32'h300);
    check("r0_ex_b", ex_b, 32'h400);

    // Immediate select
    id_rs = 5'd1; id_rt = 5'd6; id_bsel = 1'b1; id_imm = 32'hFFFF8000; id_a = 32'h55;
    mem_rw = 1'b0; wb_rw = 1'b0;
    cyc();
    mem_rw = 1'b1; mem_rd = 5'd6; mem_res = 32'hDEAD;
    #2;
    check("imm_ex_b", ex_b, 32'hFFFF8000);
    check("imm_ex_a", ex_a, 32'h55);

    // Stall retention of a one-shot WB forward
    @(negedge clk);
    mem_rw = 1'b0; id_bsel = 1'b0; id_rs = 5'd3; id_a = 32'h9;
    cyc();
    stall = 1'b1; wb_rw = 1'b1; wb_rd = 5'd3; wb_res = 32'h1234;
    #2;
    check("stl_ex_a0", ex_a, 32'h1234);
    @(negedge clk);
    wb_rw = 1'b0; id_a = 32'hEEEE;
    cyc(); #2;
    check("stl_ex_a1", ex_a, 32'h1234);
    cyc(); #2;
    check("stl_ex_a2", ex_a, 32'h1234);

    // Load-use
    @(negedge clk);
    stall = 1'b0; id_memread = 1'b1; id_rd = 5'd7; id_valid = 1'b1;
    cyc();
    stall = 1'b1; id_rs = 5'd7; id_rt = 5'd1; id_bsel = 1'b0;
    #2;
    check("lu_rs", 32'(hazard), 32'h1);
    id_rs = 5'd1; id_rt = 5'd7; id_bsel = 1'b1;
    #1;
    check("lu_imm", 32'(hazard), 32'h0);
    id_bsel = 1'b0;
    #1;
    check("lu_rt", 32'(hazard), 32'h1);
    @(negedge clk);
    stall = 1'b0; id_rd = 5'd0;
    cyc();
    stall = 1'b1; id_rs = 5'd0; id_rt = 5'd0;
    #2;
    check("lu_rd0", 32'(hazard), 32'h0);

    // Flush beats stall; asynchronous reset between edges
    @(negedge clk);
    stall = 1'b0; id_valid = 1'b1; id_regwrite = 1'b1; id_memread = 1'b0; id_rd = 5'd9;
    cyc();
    stall = 1'b1; flush = 1'b1;
    cyc(); #2;
    check("fl_valid", 32'(ex_valid), 32'h0);
    check("fl_regwrite", 32'(ex_regwrite), 32'h0);
    @(negedge clk);
    stall = 1'b0; flush = 1'b0; id_memread = 1'b1; id_rs = 5'd2;
    cyc();
    #3 rst_n = 1'b0;
    #0.5;
    check("ar_valid", 32'(ex_valid), 32'h0);
    check("ar_regwrite", 32'(ex_regwrite), 32'h0);
    check("ar_memread", 32'(ex_memread), 32'h0);
    check("ar_rd", 32'(ex_rd), 32'h0);
    check("ar_ex_a", ex_a, 32'h0);
    #0.5 rst_n = 1'b1;

    // Randomized traffic with occasional reset pulses between edges
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      randomize_inputs();
      if ($urandom_range(0, 99) == 0) begin
        #3 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
